// File: rtl/ht_blk_packer.sv
// ht_blk_packer: transmit side of the 4x4 hard-threshold block interface.
// Collects a raster-order serial coefficient stream into a 16-coefficient
// block and presents it in parallel. A fill buffer and an output register
// form a double buffer, so the next block fills while the current one
// waits for blk_oready.
// Optional feature: define HT_NZ_CNT_EN to count the nonzero coefficients
// of each block and present that count on blk_nz. Without it, blk_nz is 0.
module ht_blk_packer #(
    parameter int WIDTH0 = 13,
    parameter int NCOEF  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH0-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              blk_flush,
    output logic [WIDTH0-1:0] blk_o0,
    output logic [WIDTH0-1:0] blk_o1,
    output logic [WIDTH0-1:0] blk_o2,
    output logic [WIDTH0-1:0] blk_o3,
    output logic [WIDTH0-1:0] blk_o4,
    output logic [WIDTH0-1:0] blk_o5,
    output logic [WIDTH0-1:0] blk_o6,
    output logic [WIDTH0-1:0] blk_o7,
    output logic [WIDTH0-1:0] blk_o8,
    output logic [WIDTH0-1:0] blk_o9,
    output logic [WIDTH0-1:0] blk_o10,
    output logic [WIDTH0-1:0] blk_o11,
    output logic [WIDTH0-1:0] blk_o12,
    output logic [WIDTH0-1:0] blk_o13,
    output logic [WIDTH0-1:0] blk_o14,
    output logic [WIDTH0-1:0] blk_o15,
    output logic              blk_ovalid,
    input  logic              blk_oready,
    output logic [4:0]        blk_nz
);

    // FILL: collecting beats. HOLD: a completed block waits for the output register.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } fill_state_t;

    fill_state_t       state_r;
    fill_state_t       state_nxt_s;
    logic [3:0]        idx_r;
    logic [3:0]        idx_nxt_s;
    logic [WIDTH0-1:0] fill_mem_r [NCOEF];
    logic [WIDTH0-1:0] out_mem_r  [NCOEF];
    logic [WIDTH0-1:0] load_data_s [NCOEF];
    logic              blk_ovalid_r;
    logic              accept_s;
    logic              wr_en_s;
    logic              load_s;
    logic              out_free_s;

    // Fill-side state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Fill-side next state, beat write enable and block hand-over to the output register.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_en_s     = 1'b0;
        load_s      = 1'b0;
        accept_s    = s_valid & (state_r == ST_FILL);
        out_free_s  = ~blk_ovalid_r | blk_oready;
        case (state_r)
            ST_FILL: begin
                if (blk_flush) begin
                    // Flush wins over any beat in the same cycle, including the 16th.
                    idx_nxt_s = 4'd0;
                end else if (accept_s) begin
                    wr_en_s   = 1'b1;
                    idx_nxt_s = idx_r + 4'd1;
                    if (idx_r == 4'd15) begin
                        if (out_free_s) begin
                            load_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_HOLD;
                        end
                    end else begin
                        load_s = 1'b0;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_HOLD: begin
                if (blk_flush) begin
                    state_nxt_s = ST_FILL;
                end else if (out_free_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
                idx_nxt_s   = 4'd0;
            end
        endcase
    end

    // Block presented to the output register: on a direct hand-over the
    // 16th coefficient is still on s_data, not yet in the fill buffer.
    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            load_data_s[k] = fill_mem_r[k];
        end
        if (state_r == ST_FILL) begin
            load_data_s[NCOEF-1] = s_data;
        end else begin
            load_data_s[NCOEF-1] = fill_mem_r[NCOEF-1];
        end
    end

    // Fill buffer: accepted beats land in slot idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCOEF; k++) begin
                fill_mem_r[k] <= {WIDTH0{1'b0}};
            end
        end else if (wr_en_s) begin
            fill_mem_r[idx_r] <= s_data;
        end else begin
            fill_mem_r <= fill_mem_r;
        end
    end

    // Output register: loads a completed block, clears valid on accept, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_ovalid_r <= 1'b0;
            for (int k = 0; k < NCOEF; k++) begin
                out_mem_r[k] <= {WIDTH0{1'b0}};
            end
        end else if (load_s) begin
            blk_ovalid_r <= 1'b1;
            out_mem_r    <= load_data_s;
        end else if (blk_oready) begin
            blk_ovalid_r <= 1'b0;
        end else begin
            blk_ovalid_r <= blk_ovalid_r;
        end
    end

`ifdef HT_NZ_CNT_EN
    logic [4:0] nz_cnt_r;
    logic [4:0] nz_load_s;
    logic [4:0] blk_nz_r;

    function automatic logic [4:0] coef_nz(input logic [WIDTH0-1:0] coef);
        return (coef != {WIDTH0{1'b0}}) ? 5'd1 : 5'd0;
    endfunction

    // Count of the block being handed over; includes the 16th beat on a direct hand-over.
    always_comb begin
        if (state_r == ST_FILL) begin
            nz_load_s = nz_cnt_r + coef_nz(s_data);
        end else begin
            nz_load_s = nz_cnt_r;
        end
    end

    // Per-block nonzero counter; restarts on flush or hand-over, frozen while holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nz_cnt_r <= 5'd0;
        end else if (blk_flush || load_s) begin
            nz_cnt_r <= 5'd0;
        end else if (wr_en_s) begin
            nz_cnt_r <= nz_cnt_r + coef_nz(s_data);
        end else begin
            nz_cnt_r <= nz_cnt_r;
        end
    end

    // Nonzero count travels with the block into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_nz_r <= 5'd0;
        end else if (load_s) begin
            blk_nz_r <= nz_load_s;
        end else begin
            blk_nz_r <= blk_nz_r;
        end
    end

    assign blk_nz = blk_nz_r;
`else
    assign blk_nz = 5'd0;
`endif

    assign s_ready    = (state_r == ST_FILL);
    assign blk_ovalid = blk_ovalid_r;
    assign blk_o0     = out_mem_r[0];
    assign blk_o1     = out_mem_r[1];
    assign blk_o2     = out_mem_r[2];
    assign blk_o3     = out_mem_r[3];
    assign blk_o4     = out_mem_r[4];
    assign blk_o5     = out_mem_r[5];
    assign blk_o6     = out_mem_r[6];
    assign blk_o7     = out_mem_r[7];
    assign blk_o8     = out_mem_r[8];
    assign blk_o9     = out_mem_r[9];
    assign blk_o10    = out_mem_r[10];
    assign blk_o11    = out_mem_r[11];
    assign blk_o12    = out_mem_r[12];
    assign blk_o13    = out_mem_r[13];
    assign blk_o14    = out_mem_r[14];
    assign blk_o15    = out_mem_r[15];

endmodule

// File: tb/tb_ht_blk_packer.sv
// Testbench for ht_blk_packer: a scoreboard model of the fill side pushes
// expected blocks as beats are driven; the output side is compared against
// the queue head every cycle a block is presented.
`timescale 1ns/1ps
module tb_ht_blk_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        blk_flush;
    logic [12:0] blk_o0, blk_o1, blk_o2, blk_o3, blk_o4, blk_o5, blk_o6, blk_o7;
    logic [12:0] blk_o8, blk_o9, blk_o10, blk_o11, blk_o12, blk_o13, blk_o14, blk_o15;
    logic        blk_ovalid;
    logic        blk_oready;
    logic [4:0]  blk_nz;
    logic [207:0] dut_blk_s;

    typedef struct packed {
        logic [207:0] d;
        logic [4:0]   nz;
    } blk_t;

    blk_t         exp_q[$];
    logic [207:0] m_blk;
    int           m_idx = 0;
    int           m_nz = 0;
    int           n_blk = 0;
    int           rdy_low = 0;
    int           n_chk = 0;
    int           n_err = 0;
    int           nb;

    always #5 clk = ~clk;

    ht_blk_packer dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .blk_flush(blk_flush),
        .blk_o0(blk_o0), .blk_o1(blk_o1), .blk_o2(blk_o2), .blk_o3(blk_o3),
        .blk_o4(blk_o4), .blk_o5(blk_o5), .blk_o6(blk_o6), .blk_o7(blk_o7),
        .blk_o8(blk_o8), .blk_o9(blk_o9), .blk_o10(blk_o10), .blk_o11(blk_o11),
        .blk_o12(blk_o12), .blk_o13(blk_o13), .blk_o14(blk_o14), .blk_o15(blk_o15),
        .blk_ovalid(blk_ovalid), .blk_oready(blk_oready), .blk_nz(blk_nz)
    );

    assign dut_blk_s = {blk_o15, blk_o14, blk_o13, blk_o12, blk_o11, blk_o10, blk_o9, blk_o8,
                        blk_o7, blk_o6, blk_o5, blk_o4, blk_o3, blk_o2, blk_o1, blk_o0};

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output-side comparison and fill-side reference model, both sampled on the falling edge.
    always @(negedge clk) begin
        blk_t nb_t;
        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
            m_nz  = 0;
            m_blk = '0;
        end else begin
            check_val("blk_ovalid", blk_ovalid, (exp_q.size() != 0));
            if (blk_ovalid && exp_q.size() != 0) begin
                check_val("blk_data", dut_blk_s, exp_q[0].d);
                check_val("blk_nz", blk_nz, exp_q[0].nz);
                if (blk_oready) begin
                    void'(exp_q.pop_front());
                    n_blk++;
                end
            end
            if (s_valid && !s_ready) rdy_low++;
            if (blk_flush) begin
                m_idx = 0;
                m_nz  = 0;
            end else if (s_valid && s_ready) begin
                m_blk[m_idx*13 +: 13] = s_data;
                if (s_data != 13'd0) m_nz++;
                if (m_idx == 15) begin
                    nb_t.d = m_blk;
`ifdef HT_NZ_CNT_EN
                    nb_t.nz = 5'(m_nz);
`else
                    nb_t.nz = 5'd0;
`endif
                    exp_q.push_back(nb_t);
                    m_idx = 0;
                    m_nz  = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic push(input logic [12:0] d);
        int w = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (w >= 100) check_val("push_timeout", w, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || blk_ovalid) && w < 200) begin
            w++;
            @(negedge clk);
        end
        check_val("drain_timeout", (w < 200), 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 13'd0;
        blk_flush  = 1'b0;
        blk_oready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_val("rst_s_ready", s_ready, 1'b1);
        check_val("rst_blk_o0", blk_o0, 13'd0);
        check_val("rst_blk_o15", blk_o15, 13'd0);
        check_val("rst_blk_nz", blk_nz, 5'd0);
        @(posedge clk); #1;

        // Single block, latency and raster order
        for (int k = 0; k < 16; k++) push(13'(k + 1));
        @(negedge clk);
        check_val("t1_latency", blk_ovalid, 1'b1);
        check_val("t1_blk_o5", blk_o5, 13'd6);
        check_val("t1_blk_o15", blk_o15, 13'd16);
        wait_drain();
        @(posedge clk); #1;

        // Three back-to-back blocks at full throughput
        rdy_low = 0;
        nb = n_blk;
        for (int k = 0; k < 48; k++) push(13'(k * 7 + 3));
        wait_drain();
        check_val("t2_ready_low", rdy_low, 0);
        check_val("t2_nblk", n_blk - nb, 3);
        @(posedge clk); #1;

        // Backpressure: two blocks with blk_oready low, then release
        blk_oready = 1'b0;
        for (int k = 0; k < 32; k++) push(13'(100 + k));
        @(negedge clk);
        check_val("t3_s_ready_hold", s_ready, 1'b0);
        repeat (4) @(negedge clk);
        check_val("t3_blk1_o3", blk_o3, 13'd103);
        @(posedge clk); #1 blk_oready = 1'b1;
        @(posedge clk); #1 blk_oready = 1'b0;
        @(negedge clk);
        check_val("t3_s_ready_back", s_ready, 1'b1);
        check_val("t3_blk2_valid", blk_ovalid, 1'b1);
        check_val("t3_blk2_o0", blk_o0, 13'd116);
        @(posedge clk); #1 blk_oready = 1'b1;
        wait_drain();
        @(posedge clk); #1;

        // Flush of a partial block; the beat in the flush cycle is dropped
        nb = n_blk;
        for (int k = 0; k < 7; k++) push(13'(13'h40 + k));
        blk_flush = 1'b1; s_valid = 1'b1; s_data = 13'h077;
        @(posedge clk); #1 blk_flush = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 16; k++) push(13'h00A);
        wait_drain();
        check_val("t4_nblk", n_blk - nb, 1);
        check_val("t4_blk_o9_kept", blk_o9, 13'h00A);
        @(posedge clk); #1;

        // Flush coinciding with the 16th beat drops the block
        nb = n_blk;
        for (int k = 0; k < 15; k++) push(13'h020);
        blk_flush = 1'b1; s_valid = 1'b1; s_data = 13'h055;
        @(posedge clk); #1 blk_flush = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < 16; k++) push(13'h033);
        wait_drain();
        check_val("t4b_nblk", n_blk - nb, 1);
        check_val("t4b_blk_o15", blk_o15, 13'h033);
        @(posedge clk); #1;

        // Negative values bit-exact, six nonzero coefficients
        nb = n_blk;
        for (int k = 0; k < 16; k++) push((k < 3) ? 13'h1FFF : ((k < 6) ? 13'h1000 : 13'h0000));
        wait_drain();
        check_val("t5_nblk", n_blk - nb, 1);
        check_val("t5_blk_o0", blk_o0, 13'h1FFF);
        check_val("t5_blk_o4", blk_o4, 13'h1000);
`ifdef HT_NZ_CNT_EN
        check_val("t5_nz", blk_nz, 5'd6);
`else
        check_val("t5_nz", blk_nz, 5'd0);
`endif
        @(posedge clk); #1;

        // Reset mid-block: nothing emitted, fill index restarts
        nb = n_blk;
        for (int k = 0; k < 9; k++) push(13'h0111);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t6_nblk", n_blk - nb, 0);
        check_val("t6_ovalid", blk_ovalid, 1'b0);
        check_val("t6_blk_o0", blk_o0, 13'd0);
        check_val("t6_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) push(13'(k * 3));
        wait_drain();
        check_val("t6_post_o1", blk_o1, 13'd3);
        check_val("t6_post_nblk", n_blk - nb, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
